bp_be_context_switch_ctrl: RTL and testbench

Sequencer that performs a hardware thread context switch in the BE and drives the per-thread context store. It accepts a switch request from the CTXT CSR write, stalls issue, and drains the pipeline. It then saves the live architectural state of the outgoing thread into the store, changes the active thread ID, reads back the incoming thread's state, and issues one redirect to the FE. It is the writer/selector counterpart of the per-thread context storage.

---
 rtl/bp_be_pkg.sv | 23 ++
 rtl/bp_be_context_switch_ctrl.sv | 138 +++++++++++++
 tb/tb_bp_be_context_switch_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared BE types for the context-switch sequencer
package bp_be_pkg;

    localparam int bp_be_vaddr_width_gp = 64;
    localparam int bp_be_asid_width_gp  = 16;

    typedef enum logic [2:0] {
        e_idle,
        e_drain,
        e_save,
        e_restore,
        e_redirect,
        e_done
    } bp_be_ctxsw_state_e;

    typedef struct packed {
        logic [bp_be_vaddr_width_gp-1:0] npc;
        logic [1:0]                      priv;
        logic                            tran_en;
        logic [bp_be_asid_width_gp-1:0]  asid;
    } bp_be_thread_ctx_s;

endpackage

// File: rtl/bp_be_context_switch_ctrl.sv
// rtl/bp_be_context_switch_ctrl.sv - drain/save/restore/redirect sequencer for hardware thread switches
module bp_be_context_switch_ctrl
    import bp_be_pkg::*;
#(
    parameter  int num_threads_p = 4,
    parameter  int vaddr_width_p = bp_be_vaddr_width_gp,
    parameter  int asid_width_p  = bp_be_asid_width_gp,
    localparam int tid_width_lp  = $clog2(num_threads_p) + 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     switch_v_i,
    input  logic [tid_width_lp-1:0]  switch_tid_i,
    output logic                     switch_ready_o,
    output logic                     switch_error_o,
    output logic                     switch_done_o,
    output logic                     hold_o,

    input  logic                     pipe_empty_i,
    input  logic [vaddr_width_p-1:0] live_npc_i,
    input  logic [1:0]               live_priv_i,
    input  logic                     live_tran_en_i,
    input  logic [asid_width_p-1:0]  live_asid_i,

    output logic                     save_v_o,
    output logic [tid_width_lp-1:0]  save_tid_o,
    output logic [vaddr_width_p-1:0] save_npc_o,
    output logic [1:0]               save_priv_o,
    output logic                     save_tran_en_o,
    output logic [asid_width_p-1:0]  save_asid_o,

    output logic [tid_width_lp-1:0]  current_thread_id_o,

    input  logic [vaddr_width_p-1:0] ctx_npc_i,
    input  logic [1:0]               ctx_priv_i,
    input  logic                     ctx_tran_en_i,
    input  logic [asid_width_p-1:0]  ctx_asid_i,

    output logic                     redirect_v_o,
    output logic [vaddr_width_p-1:0] redirect_npc_o,
    output logic [1:0]               redirect_priv_o,
    output logic                     redirect_tran_en_o,
    output logic [asid_width_p-1:0]  redirect_asid_o,
    input  logic                     redirect_yumi_i,

    output logic [15:0]              switch_count_o
);

    localparam logic [tid_width_lp-1:0] num_threads_tid_lp = tid_width_lp'(num_threads_p);

    bp_be_ctxsw_state_e        state_q, state_d;
    logic [tid_width_lp-1:0]   cur_tid_q, target_q;
    logic                      error_q;
    logic [15:0]               count_q;
    bp_be_thread_ctx_s         redirect_q;
    bp_be_thread_ctx_s         live_ctx, store_ctx;

    logic accept, tid_bad, tid_same;

    assign live_ctx  = '{npc: live_npc_i, priv: live_priv_i, tran_en: live_tran_en_i, asid: live_asid_i};
    assign store_ctx = '{npc: ctx_npc_i, priv: ctx_priv_i, tran_en: ctx_tran_en_i, asid: ctx_asid_i};

    assign accept   = (state_q == e_idle) && switch_v_i;
    assign tid_bad  = switch_tid_i >= num_threads_tid_lp;
    assign tid_same = switch_tid_i == cur_tid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            cur_tid_q  <= '0;
            target_q   <= '0;
            error_q    <= 1'b0;
            count_q    <= '0;
            redirect_q <= '0;
        end else begin
            state_q <= state_d;
            error_q <= accept && tid_bad;
            if (accept && !tid_bad) begin
                target_q <= switch_tid_i;
            end
            // Thread ID flips only on the edge that ends SAVE, so the store never
            // sees a save strobe and an index change in the same cycle.
            if (state_q == e_save) begin
                cur_tid_q <= target_q;
            end
            if (state_q == e_restore) begin
                redirect_q <= store_ctx;
            end
            // Counted on the edge into DONE so the done pulse already shows the new total.
            if ((state_q == e_redirect) && redirect_yumi_i && (count_q != 16'hFFFF)) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            e_idle: begin
                if (switch_v_i && !tid_bad) begin
                    state_d = tid_same ? e_done : e_drain;
                end
            end
            e_drain:    if (pipe_empty_i) state_d = e_save;
            e_save:     state_d = e_restore;
            e_restore:  state_d = e_redirect;
            e_redirect: if (redirect_yumi_i) state_d = e_done;
            e_done:     state_d = e_idle;
            default:    state_d = e_idle;
        endcase
    end

    always_comb begin
        switch_ready_o = (state_q == e_idle);
        hold_o         = (state_q == e_drain) || (state_q == e_save)
                      || (state_q == e_restore) || (state_q == e_redirect);
        save_v_o       = (state_q == e_save);
        redirect_v_o   = (state_q == e_redirect);
        switch_done_o  = (state_q == e_done);
    end

    assign switch_error_o      = error_q;
    assign current_thread_id_o = cur_tid_q;
    assign switch_count_o      = count_q;

    assign save_tid_o          = cur_tid_q;
    assign save_npc_o          = live_ctx.npc;
    assign save_priv_o         = live_ctx.priv;
    assign save_tran_en_o      = live_ctx.tran_en;
    assign save_asid_o         = live_ctx.asid;

    assign redirect_npc_o      = redirect_q.npc;
    assign redirect_priv_o     = redirect_q.priv;
    assign redirect_tran_en_o  = redirect_q.tran_en;
    assign redirect_asid_o     = redirect_q.asid;

endmodule

// File: tb/tb_bp_be_context_switch_ctrl.sv
// tb/tb_bp_be_context_switch_ctrl.sv - directed vector bench for bp_be_context_switch_ctrl
module tb_bp_be_context_switch_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        switch_v_i;
    logic [2:0]  switch_tid_i;
    logic        switch_ready_o, switch_error_o, switch_done_o, hold_o;
    logic        pipe_empty_i;
    logic [63:0] live_npc_i;
    logic [1:0]  live_priv_i;
    logic        live_tran_en_i;
    logic [15:0] live_asid_i;
    logic        save_v_o;
    logic [2:0]  save_tid_o;
    logic [63:0] save_npc_o;
    logic [1:0]  save_priv_o;
    logic        save_tran_en_o;
    logic [15:0] save_asid_o;
    logic [2:0]  current_thread_id_o;
    logic [63:0] ctx_npc_i;
    logic [1:0]  ctx_priv_i;
    logic        ctx_tran_en_i;
    logic [15:0] ctx_asid_i;
    logic        redirect_v_o;
    logic [63:0] redirect_npc_o;
    logic [1:0]  redirect_priv_o;
    logic        redirect_tran_en_o;
    logic [15:0] redirect_asid_o;
    logic        redirect_yumi_i;
    logic [15:0] switch_count_o;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    bp_be_context_switch_ctrl dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .switch_v_i          (switch_v_i),
        .switch_tid_i        (switch_tid_i),
        .switch_ready_o      (switch_ready_o),
        .switch_error_o      (switch_error_o),
        .switch_done_o       (switch_done_o),
        .hold_o              (hold_o),
        .pipe_empty_i        (pipe_empty_i),
        .live_npc_i          (live_npc_i),
        .live_priv_i         (live_priv_i),
        .live_tran_en_i      (live_tran_en_i),
        .live_asid_i         (live_asid_i),
        .save_v_o            (save_v_o),
        .save_tid_o          (save_tid_o),
        .save_npc_o          (save_npc_o),
        .save_priv_o         (save_priv_o),
        .save_tran_en_o      (save_tran_en_o),
        .save_asid_o         (save_asid_o),
        .current_thread_id_o (current_thread_id_o),
        .ctx_npc_i           (ctx_npc_i),
        .ctx_priv_i          (ctx_priv_i),
        .ctx_tran_en_i       (ctx_tran_en_i),
        .ctx_asid_i          (ctx_asid_i),
        .redirect_v_o        (redirect_v_o),
        .redirect_npc_o      (redirect_npc_o),
        .redirect_priv_o     (redirect_priv_o),
        .redirect_tran_en_o  (redirect_tran_en_o),
        .redirect_asid_o     (redirect_asid_o),
        .redirect_yumi_i     (redirect_yumi_i),
        .switch_count_o      (switch_count_o)
    );

    typedef struct {
        logic        v;
        logic [2:0]  tid;
        logic        rdy;
        logic        hold;
        logic        sv;
        logic [2:0]  stid;
        logic [2:0]  cur;
        logic        rv;
        logic        done;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic v, input logic [2:0] tid, input logic rdy,
                                input logic hold, input logic sv, input logic [2:0] stid,
                                input logic [2:0] cur, input logic rv, input logic done,
                                input logic err, input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.tid = tid; r.rdy = rdy; r.hold = hold; r.sv = sv; r.stid = stid;
        r.cur = cur; r.rv = rv; r.done = done; r.err = err; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (switch_done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, {63'd0, seen}, 64'd1);
    endtask

    localparam logic [63:0] LIVE0 = 64'h8000_1000;
    localparam logic [63:0] CTX0  = 64'h8000_4000;

    initial begin
        reset_i = 1'b1; switch_v_i = 1'b0; switch_tid_i = '0; pipe_empty_i = 1'b1;
        live_npc_i = LIVE0; live_priv_i = 2'd1; live_tran_en_i = 1'b1; live_asid_i = 16'h00AA;
        ctx_npc_i = CTX0; ctx_priv_i = 2'd3; ctx_tran_en_i = 1'b0; ctx_asid_i = 16'h1234;
        redirect_yumi_i = 1'b1;

        //             v  tid  rdy hold sv stid cur rv done err cnt
        vecs[0]  = mk(1, 3'd2, 1, 0, 0, 3'd0, 3'd0, 0, 0, 0, 16'd0);
        vecs[1]  = mk(1, 3'd3, 0, 1, 0, 3'd0, 3'd0, 0, 0, 0, 16'd0);
        vecs[2]  = mk(0, 3'd0, 0, 1, 1, 3'd0, 3'd0, 0, 0, 0, 16'd0);
        vecs[3]  = mk(0, 3'd0, 0, 1, 0, 3'd2, 3'd2, 0, 0, 0, 16'd0);
        vecs[4]  = mk(0, 3'd0, 0, 1, 0, 3'd2, 3'd2, 1, 0, 0, 16'd0);
        vecs[5]  = mk(0, 3'd0, 0, 0, 0, 3'd2, 3'd2, 0, 1, 0, 16'd1);
        vecs[6]  = mk(1, 3'd5, 1, 0, 0, 3'd2, 3'd2, 0, 0, 0, 16'd1);
        vecs[7]  = mk(0, 3'd0, 1, 0, 0, 3'd2, 3'd2, 0, 0, 1, 16'd1);
        vecs[8]  = mk(1, 3'd4, 1, 0, 0, 3'd2, 3'd2, 0, 0, 0, 16'd1);
        vecs[9]  = mk(1, 3'd2, 1, 0, 0, 3'd2, 3'd2, 0, 0, 1, 16'd1);
        vecs[10] = mk(0, 3'd0, 0, 0, 0, 3'd2, 3'd2, 0, 1, 0, 16'd1);
        vecs[11] = mk(0, 3'd0, 1, 0, 0, 3'd2, 3'd2, 0, 0, 0, 16'd1);

        tick(); tick();
        reset_i = 1'b0;

        for (int c = 0; c < 5; c++) begin
            tick();
            #3;
            chk("rst_cur", {61'd0, current_thread_id_o}, 64'd0);
            chk("rst_hold", {63'd0, hold_o}, 64'd0);
            chk("rst_ready", {63'd0, switch_ready_o}, 64'd1);
            chk("rst_count", {48'd0, switch_count_o}, 64'd0);
        end
        chk("rst_redir_npc", redirect_npc_o, 64'd0);

        // Real switch 0->2, error tids 5 and 4, then a same-thread request.
        tick();
        for (int i = 0; i < 12; i++) begin
            switch_v_i   = vecs[i].v;
            switch_tid_i = vecs[i].tid;
            #3;
            chk($sformatf("v%0d_ready", i), {63'd0, switch_ready_o}, {63'd0, vecs[i].rdy});
            chk($sformatf("v%0d_hold", i), {63'd0, hold_o}, {63'd0, vecs[i].hold});
            chk($sformatf("v%0d_save_v", i), {63'd0, save_v_o}, {63'd0, vecs[i].sv});
            chk($sformatf("v%0d_save_tid", i), {61'd0, save_tid_o}, {61'd0, vecs[i].stid});
            chk($sformatf("v%0d_cur", i), {61'd0, current_thread_id_o}, {61'd0, vecs[i].cur});
            chk($sformatf("v%0d_redir_v", i), {63'd0, redirect_v_o}, {63'd0, vecs[i].rv});
            chk($sformatf("v%0d_done", i), {63'd0, switch_done_o}, {63'd0, vecs[i].done});
            chk($sformatf("v%0d_error", i), {63'd0, switch_error_o}, {63'd0, vecs[i].err});
            chk($sformatf("v%0d_count", i), {48'd0, switch_count_o}, {48'd0, vecs[i].cnt});
            if (vecs[i].sv) chk($sformatf("v%0d_save_npc", i), save_npc_o, LIVE0);
            if (vecs[i].rv) chk($sformatf("v%0d_redir_npc", i), redirect_npc_o, CTX0);
            tick();
        end

        // Slow drain: switch 2->1 with the pipe busy for 7 cycles.
        live_npc_i = 64'h8000_2000; live_priv_i = 2'd0; live_asid_i = 16'h0055;
        pipe_empty_i = 1'b0; switch_v_i = 1'b1; switch_tid_i = 3'd1;
        tick();
        switch_v_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #3;
            chk("drain_hold", {63'd0, hold_o}, 64'd1);
            chk("drain_no_save", {63'd0, save_v_o}, 64'd0);
            tick();
        end
        pipe_empty_i = 1'b1;
        #3;
        chk("drain_last_no_save", {63'd0, save_v_o}, 64'd0);
        tick();
        #3;
        chk("drain_save_v", {63'd0, save_v_o}, 64'd1);
        chk("drain_save_tid", {61'd0, save_tid_o}, 64'd2);
        chk("drain_save_npc", save_npc_o, 64'h8000_2000);
        chk("drain_save_priv", {62'd0, save_priv_o}, 64'd0);
        chk("drain_save_asid", {48'd0, save_asid_o}, 64'h55);
        chk("drain_cur_in_save", {61'd0, current_thread_id_o}, 64'd2);
        tick();
        #3;
        chk("drain_cur_new", {61'd0, current_thread_id_o}, 64'd1);
        tick();
        wait_done("drain_done");
        chk("drain_count", {48'd0, switch_count_o}, 64'd2);
        tick();

        // Reset while parked in REDIRECT, then a fresh switch.
        redirect_yumi_i = 1'b0; ctx_npc_i = 64'h8000_7000;
        switch_v_i = 1'b1; switch_tid_i = 3'd3;
        tick();
        switch_v_i = 1'b0;
        tick(); tick(); tick();
        #3;
        chk("park_redir_v", {63'd0, redirect_v_o}, 64'd1);
        chk("park_redir_npc", redirect_npc_o, 64'h8000_7000);
        chk("park_redir_priv", {62'd0, redirect_priv_o}, 64'd3);
        chk("park_redir_asid", {48'd0, redirect_asid_o}, 64'h1234);
        ctx_npc_i = 64'h0000_DEAD;
        tick();
        #3;
        chk("park_stable_v", {63'd0, redirect_v_o}, 64'd1);
        chk("park_stable_npc", redirect_npc_o, 64'h8000_7000);
        chk("park_cur", {61'd0, current_thread_id_o}, 64'd3);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #3;
        chk("abort_redir_v", {63'd0, redirect_v_o}, 64'd0);
        chk("abort_cur", {61'd0, current_thread_id_o}, 64'd0);
        chk("abort_done", {63'd0, switch_done_o}, 64'd0);
        chk("abort_ready", {63'd0, switch_ready_o}, 64'd1);
        chk("abort_hold", {63'd0, hold_o}, 64'd0);
        tick();
        #3;
        chk("abort_no_done", {63'd0, switch_done_o}, 64'd0);
        redirect_yumi_i = 1'b1; ctx_npc_i = 64'h8000_9000;
        switch_v_i = 1'b1; switch_tid_i = 3'd1;
        tick();
        switch_v_i = 1'b0;
        wait_done("post_abort_done");
        chk("post_abort_cur", {61'd0, current_thread_id_o}, 64'd1);
        chk("post_abort_count", {48'd0, switch_count_o}, 64'd1);
        chk("post_abort_npc", redirect_npc_o, 64'h8000_9000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
